// File: rtl/divider_pkg.sv
// divider_pkg: definitions shared by the serial divider.
//   div_op_e  : RISC-V divide opcode encoding (DIVU/DIV/REMU/REM).
//   DIV_CNT_W : width of the iteration counter for a given operand width.
//               It must be able to hold the value WIDTH itself.
package divider_pkg;

    typedef enum logic [1:0] {
        DIVU = 2'd0,
        DIV  = 2'd1,
        REMU = 2'd2,
        REM  = 2'd3
    } div_op_e;

    function automatic int DIV_CNT_W(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/lzc.sv
// lzc: leading/trailing zero counter.
//   WIDTH   : input width.
//   MODE    : 0 counts trailing zeros, 1 counts leading zeros.
//   in_i    : input vector.
//   cnt_o   : zero count. It is only meaningful when empty_o is low.
//   empty_o : high when in_i is all zeros.
module lzc #(
    parameter int WIDTH     = 64,
    parameter bit MODE      = 1'b0,
    parameter int CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // The loop keeps overwriting the count, so the last set bit it visits
    // wins. That bit is the most significant one in leading-zero mode and
    // the least significant one in trailing-zero mode.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end else begin
                if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/serial_divider.sv
// serial_divider: multi-cycle radix-2 divider for DIV/DIVU/REM/REMU.
// The divisor is pre-aligned to the dividend using leading-zero counts, so
// the divider only iterates over the significant quotient bits.
// Ports:
//   clk_i, rst_i        : clock and asynchronous active-high reset.
//   flush_i             : kills any in-flight operation.
//   in_vld_i / in_rdy_o : request handshake.
//   op_a_i, op_b_i      : dividend and divisor.
//   opcode_i            : div_op_e encoding.
//   id_i                : request tag.
//   out_vld_o/out_rdy_i : result handshake.
//   res_o               : quotient or remainder.
//   id_o                : tag of the result.
module serial_divider
    import divider_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [1:0]               opcode_i,
    input  logic [TRANS_ID_BITS-1:0] id_i,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [WIDTH-1:0]         res_o,
    output logic [TRANS_ID_BITS-1:0] id_o
);

    localparam int CNT_W = DIV_CNT_W(WIDTH);
    localparam int LZ_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

    state_e                   state_q, state_d;
    logic [WIDTH-1:0]         r_q, r_d, d_q, d_d, q_q, q_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic [TRANS_ID_BITS-1:0] id_q, id_d;
    logic                     neg_q_q, neg_q_d;   // negate the quotient
    logic                     neg_r_q, neg_r_d;   // negate the remainder
    logic                     rem_q, rem_d;       // return the remainder
    logic                     bypass_q, bypass_d; // result is already final

    // Operand preparation. |min| is kept as the unsigned value 2^(WIDTH-1).
    div_op_e          op;
    logic             is_signed, is_rem, sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [LZ_W-1:0]  za, zb, shift;
    logic             a_zero, b_zero, overflow;
    logic [CNT_W-1:0] n_init;

    assign op        = div_op_e'(opcode_i);
    assign is_signed = (op == DIV) || (op == REM);
    assign is_rem    = (op == REMU) || (op == REM);
    assign sign_a    = is_signed && op_a_i[WIDTH-1];
    assign sign_b    = is_signed && op_b_i[WIDTH-1];
    assign abs_a     = sign_a ? -op_a_i : op_a_i;
    assign abs_b     = sign_b ? -op_b_i : op_b_i;

    lzc #(.WIDTH(WIDTH), .MODE(1'b1)) u_lzc_a (
        .in_i    (abs_a),
        .cnt_o   (za),
        .empty_o (a_zero)
    );

    lzc #(.WIDTH(WIDTH), .MODE(1'b1)) u_lzc_b (
        .in_i    (abs_b),
        .cnt_o   (zb),
        .empty_o (b_zero)
    );

    assign overflow = is_signed && (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b_i);
    assign shift    = zb - za;
    assign n_init   = CNT_W'(shift) + CNT_W'(1);

    assign in_rdy_o = (state_q == IDLE) && !flush_i;

    always_comb begin
        // NOTE: every signal gets a default first so that no path through
        // the case statement leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        r_d      = r_q;
        d_d      = d_q;
        q_d      = q_q;
        n_d      = n_q;
        id_d     = id_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        rem_d    = rem_q;
        bypass_d = bypass_q;

        unique case (state_q)
            IDLE: begin
                if (in_vld_i && in_rdy_o) begin
                    id_d     = id_i;
                    rem_d    = is_rem;
                    neg_q_d  = sign_a ^ sign_b;
                    neg_r_d  = sign_a;
                    bypass_d = 1'b0;
                    q_d      = '0;
                    r_d      = abs_a;
                    d_d      = abs_b << shift;
                    n_d      = '0;
                    state_d  = FINISH;
                    if (b_zero) begin
                        // Divide by zero: the raw dividend is the remainder.
                        q_d      = '1;
                        r_d      = op_a_i;
                        bypass_d = 1'b1;
                    end else if (overflow) begin
                        q_d      = {1'b1, {(WIDTH-1){1'b0}}};
                        r_d      = '0;
                        bypass_d = 1'b1;
                    end else if (!a_zero && (za <= zb)) begin
                        n_d     = n_init;
                        state_d = DIVIDE;
                    end
                    // Otherwise |a| < |b| or a == 0: Q=0, R=|a|.
                end
            end

            DIVIDE: begin
                if (r_q >= d_q) begin
                    r_d = r_q - d_q;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                d_d = d_q >> 1;
                n_d = n_q - CNT_W'(1);
                if (n_q == CNT_W'(1)) state_d = FINISH;
            end

            FINISH: begin
                if (out_rdy_i) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // A flush overrides everything, including a result handshake.
        if (flush_i) state_d = IDLE;
    end

    // NOTE: state registers use non-blocking assignments so that every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            r_q      <= '0;
            d_q      <= '0;
            q_q      <= '0;
            n_q      <= '0;
            id_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            rem_q    <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            d_q      <= d_d;
            q_q      <= q_d;
            n_q      <= n_d;
            id_q     <= id_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            rem_q    <= rem_d;
            bypass_q <= bypass_d;
        end
    end

    // Sign correction. The registers do not change while in FINISH, so the
    // result stays stable until the handshake.
    logic [WIDTH-1:0] q_fix, r_fix;
    assign q_fix = (neg_q_q && !bypass_q) ? -q_q : q_q;
    assign r_fix = (neg_r_q && !bypass_q) ? -r_q : r_q;

    assign res_o     = rem_q ? r_fix : q_fix;
    assign id_o      = id_q;
    assign out_vld_o = (state_q == FINISH) && !flush_i;

endmodule

// File: tb/tb_serial_divider.sv
// tb_serial_divider: directed self-checking bench for serial_divider.
module tb_serial_divider;
    import divider_pkg::*;

    localparam int W   = 64;
    localparam int IDW = 3;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_vld;
    logic           in_rdy;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [1:0]     opcode;
    logic [IDW-1:0] id_in;
    logic           out_vld;
    logic           out_rdy;
    logic [W-1:0]   res;
    logic [IDW-1:0] id_out;

    int checks = 0;
    int errors = 0;

    serial_divider #(.WIDTH(W), .TRANS_ID_BITS(IDW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .in_vld_i  (in_vld),
        .in_rdy_o  (in_rdy),
        .op_a_i    (op_a),
        .op_b_i    (op_b),
        .opcode_i  (opcode),
        .id_i      (id_in),
        .out_vld_o (out_vld),
        .out_rdy_i (out_rdy),
        .res_o     (res),
        .id_o      (id_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it for one accepting edge.
    task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [IDW-1:0] id);
        int waited = 0;
        while (!in_rdy && waited < 100) begin
            step();
            waited++;
        end
        check($sformatf("%s in_rdy before accept", tag), W'(in_rdy), W'(1));
        in_vld = 1'b1;
        opcode = op;
        op_a   = a;
        op_b   = b;
        id_in  = id;
        step();
        in_vld = 1'b0;
    endtask

    // Issue one operation, check latency, result and tag, optionally stall
    // the consumer for some cycles, then complete the handshake.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [IDW-1:0] id,
                          input logic [W-1:0] exp_res, input int exp_n, input int hold);
        int lat = 0;
        issue(tag, op, a, b, id);
        // Now in cycle T+1; out_vld_o is due in cycle T+N+1.
        while (!out_vld && lat < 200) begin
            step();
            lat++;
        end
        check($sformatf("%s latency", tag), W'(lat), W'(exp_n));
        check($sformatf("%s res", tag), res, exp_res);
        check($sformatf("%s id", tag), W'(id_out), W'(id));
        for (int i = 0; i < hold; i++) begin
            step();
            check($sformatf("%s stall%0d vld", tag, i), W'(out_vld), W'(1));
            check($sformatf("%s stall%0d res", tag, i), res, exp_res);
            check($sformatf("%s stall%0d id", tag, i), W'(id_out), W'(id));
            check($sformatf("%s stall%0d in_rdy", tag, i), W'(in_rdy), W'(0));
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        #1;
        check($sformatf("%s in_rdy after", tag), W'(in_rdy), W'(1));
        check($sformatf("%s vld after", tag), W'(out_vld), W'(0));
    endtask

    initial begin
        int vld_seen;
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        op_a    = '0;
        op_b    = '0;
        opcode  = 2'd0;
        id_in   = '0;
        #1;
        check("reset vld", W'(out_vld), W'(0));
        check("reset res", res, '0);
        check("reset id", W'(id_out), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset in_rdy", W'(in_rdy), W'(1));

        // Unsigned: 100/7 -> N=5, and 3 cycles of consumer back-pressure.
        run_op("divu 100/7", DIVU, W'(100), W'(7), 3'd5, W'(14), 5, 3);
        run_op("remu 100/7", REMU, W'(100), W'(7), 3'd5, W'(2), 5, 0);

        // Signed with sign correction (N=2).
        run_op("div -7/2", DIV, -W'(7), W'(2), 3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 2, 0);
        run_op("rem -7/2", REM, -W'(7), W'(2), 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_op("rem 7/-2", REM, W'(7), -W'(2), 3'd3, W'(1), 2, 0);

        // Divide by zero.
        run_op("divu 5/0", DIVU, W'(5), '0, 3'd4, ONES, 0, 0);
        run_op("remu 5/0", REMU, W'(5), '0, 3'd6, W'(5), 0, 0);
        run_op("div -5/0", DIV, -W'(5), '0, 3'd7, ONES, 0, 0);
        run_op("rem -5/0", REM, -W'(5), '0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0);

        // Signed overflow.
        run_op("div min/-1", DIV, MIN, ONES, 3'd2, MIN, 0, 0);
        run_op("rem min/-1", REM, MIN, ONES, 3'd3, '0, 0, 0);

        // |a| < |b| and zero dividend skip the iteration.
        run_op("divu 3/100", DIVU, W'(3), W'(100), 3'd1, '0, 0, 0);
        run_op("rem -3/100", REM, -W'(3), W'(100), 3'd1, -W'(3), 0, 0);
        run_op("div 0/5", DIV, '0, W'(5), 3'd5, '0, 0, 0);

        // Worst-case iteration count.
        run_op("divu ones/1", DIVU, ONES, W'(1), 3'd6, ONES, 64, 0);

        // Flush in cycle T+10 of a 64-iteration operation.
        issue("flush", DIVU, ONES, W'(1), 3'd4);
        repeat (9) step();
        flush = 1'b1;
        #1;
        check("flush in_rdy during", W'(in_rdy), W'(0));
        check("flush vld during", W'(out_vld), W'(0));
        step();
        flush = 1'b0;
        #1;
        check("flush in_rdy T+11", W'(in_rdy), W'(1));
        vld_seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_vld) vld_seen++;
            step();
        end
        check("flush no result", W'(vld_seen), W'(0));
        run_op("divu 9/3", DIVU, W'(9), W'(3), 3'd3, W'(3), 3, 0);

        // Reset in the middle of an operation loses it.
        issue("midreset", DIVU, ONES, W'(1), 3'd7);
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("midreset vld", W'(out_vld), W'(0));
        check("midreset res", res, '0);
        check("midreset id", W'(id_out), W'(0));
        step();
        rst = 1'b0;
        #1;
        check("midreset in_rdy", W'(in_rdy), W'(1));
        vld_seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_vld) vld_seen++;
            step();
        end
        check("midreset no result", W'(vld_seen), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
